register_file_scoreboard: RTL
=============================

// Module: register_file_scoreboard
// PURPOSE
//  Core register file: the write-back port accepts {wb_rf_wb, wb_rd, wb_data} from the write-back stage.
//  Two read ports serve decode.
//  A per-register pending-write scoreboard stalls decode on RAW hazards until write-back retires the producer.
// PARAMETERS
//  XLEN     32  data width
//  PEND_W   2   pending-write counter width; max in-flight writes per rd = 2**PEND_W-1
// PORTS
//  clk            in   1     single clock; all state updates on rising edge
//  rst            in   1     synchronous, active-high reset
//  wb_rf_wb       in   1     write-back enable from write-back stage
//  wb_rd          in   5     write-back destination register
//  wb_data        in   XLEN  write-back data
//  rs1_addr       in   5     read port 1 address (decode)
//  rs2_addr       in   5     read port 2 address (decode)
//  rs1_data       out  XLEN  read port 1 data, combinational
//  rs2_data       out  XLEN  read port 2 data, combinational
//  rs1_busy       out  1     rs1 has a pending write
//  rs2_busy       out  1     rs2 has a pending write
//  issue_valid    in   1     decode presents an instruction this cycle
//  issue_rf_wb    in   1     that instruction will write rd
//  issue_rd       in   5     its destination register
//  issue_ready    out  1     pending counter of issue_rd is not saturated
//  hazard_stall   out  1     decode must hold; issue is not accepted
//  cancel_valid   in   1     a killed in-flight writer is retired without write-back
//  cancel_rd      in   5     rd of the killed writer
//  err_underflow  out  1     sticky flag: retire seen on a register with zero pending writes
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - x1..x31 <= 0; all counters <= 0; err_underflow <= 0.
//   - After reset: busy=0, issue_ready=1, hazard_stall=0, read data=0.
//  x0:
//   - Reads always return 0 and are never busy.
//   - Writes, issues and cancels targeting x0 are ignored.
//  Write:
//   - If wb_rf_wb and wb_rd!=0, regs[wb_rd] <= wb_data at clk edge.
//   - The write happens regardless of the counter value.
//  Read: combinational, from the array (see CONFIGURATION for same-cycle write).
//  Busy: rsN_busy = (cnt[rsN_addr] != 0).
//  issue_ready = (cnt[issue_rd] != 2**PEND_W-1).
//  hazard_stall = rs1_busy | rs2_busy | (issue_valid & issue_rf_wb & ~issue_ready).
//  Issue fire:
//   - Condition: issue_valid & issue_rf_wb & issue_rd!=0 & ~hazard_stall.
//   - Effect: cnt[issue_rd] +1 next edge.
//  Retire:
//   - Sources: wb_rf_wb with wb_rd!=0, or cancel_valid with cancel_rd!=0.
//   - Each source decrements its counter by 1.
//  Simultaneous events on the same rd:
//   - Net delta = fires - retires, applied once.
//   - wb and cancel to the same rd = -2.
//  Decrement below 0:
//   - Counter clamps at 0 and err_underflow <= 1.
//   - err_underflow holds until rst.
//  Saturation: a fire at max cannot occur because hazard_stall blocks it.
//  Latency:
//   - Issue is visible on busy the next cycle.
//   - Write is visible on read data the next cycle (same cycle with bypass).
// CONFIGURATION
//  Macro RF_BYPASS_EN.
//  Defined:
//   - If wb_rf_wb and wb_rd==rsN_addr!=0, rsN_data = wb_data in the same cycle.
//   - rsN_busy uses the post-retire count, so cnt==1 plus a same-cycle wb gives busy=0.
//  Undefined:
//   - Read returns the array value; busy uses the registered count.
//   - Consumer sees the new data one cycle later.
// STRUCTURE
//  Package mico_core_pkg:
//   - XLEN, REG_ADDR_W=5.
//   - Control-word field positions for the 9-bit word {rf_wb, wb_src[1:0], pc_src, rd[4:0]}.
//   - WB_SRC_ALU=2'b00/2'b01, WB_SRC_MEM=2'b10.
//  Sub-module pending_counter:
//   - Parameter PEND_W; inputs inc, dec_a, dec_b; outputs cnt, underflow.
//   - Generated for x1..x31.
// TESTING
//  1. Reset, read rs1=5 -> rs1_data=0, rs1_busy=0, issue_ready=1, hazard_stall=0.
//  2. Issue rd=5; next cycle rs1_addr=5 -> busy=1, stall=1; wb rd=5 0xDEADBEEF -> next cycle busy=0, data=0xDEADBEEF.
//  3. wb rd=0 0x1234, issue rd=0 -> rs1_addr=0 reads 0, busy stays 0, cnt untouched.
//  4. wb rd=7 0xA5A5A5A5 with rs2_addr=7 same cycle -> RF_BYPASS_EN: rs2_data=0xA5A5A5A5 same cycle; else old value, new value next cycle.
//  5. PEND_W=2: three issues rd=3 (rs addrs free) -> issue_ready=0, stall on 4th; issue+wb same rd same cycle -> count unchanged.
//  6. wb rd=9 with cnt=0 -> regs[9] written, err_underflow=1 and held until rst; cancel rd=4 after one issue -> busy clears, no error.

Source files
------------

// File: rtl/mico_core_pkg.sv
// mico_core_pkg: shared core widths, control-word layout and write-back source encodings
package mico_core_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CW_W = 9;
  localparam int CW_RD_LSB = 0;
  localparam int CW_RD_MSB = 4;
  localparam int CW_PC_SRC = 5;
  localparam int CW_WB_SRC_LSB = 6;
  localparam int CW_WB_SRC_MSB = 7;
  localparam int CW_RF_WB = 8;
  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_ALU_ALT = 2'b01;
  localparam logic [1:0] WB_SRC_MEM = 2'b10;
  typedef struct packed {
    logic rf_wb;
    logic [1:0] wb_src;
    logic pc_src;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_word_t;
  function automatic ctrl_word_t unpack_cw(input logic [CW_W-1:0] cw);
    ctrl_word_t c;
    c.rf_wb = cw[CW_RF_WB];
    c.wb_src = cw[CW_WB_SRC_MSB:CW_WB_SRC_LSB];
    c.pc_src = cw[CW_PC_SRC];
    c.rd = cw[CW_RD_MSB:CW_RD_LSB];
    return c;
  endfunction
  function automatic logic wb_from_mem(input logic [1:0] wb_src);
    return wb_src == WB_SRC_MEM;
  endfunction
endpackage

// File: rtl/pending_counter.sv
// pending_counter: in-flight write counter for one register; clamps at zero and flags underflow
module pending_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec_a,
  input  logic              dec_b,
  output logic [PEND_W-1:0] cnt,
  output logic              underflow
);
  localparam int W = PEND_W + 2;
  logic [W-1:0] nxt;
  always_comb begin
    nxt = W'(cnt) + W'(inc) - W'(dec_a) - W'(dec_b);
    underflow = nxt[W-1];
  end
  // issue is blocked at saturation, so the overflow guard never engages in practice
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= underflow ? '0 : nxt[PEND_W] ? '1 : nxt[PEND_W-1:0];
endmodule

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: 2R1W register file with per-register pending-write scoreboard for RAW stalls
// RF_BYPASS_EN: forward same-cycle write-back data to reads and use post-retire counts for busy
module register_file_scoreboard
  import mico_core_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_rf_wb,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  issue_valid,
  input  logic                  issue_rf_wb,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  output logic                  hazard_stall,
  input  logic                  cancel_valid,
  input  logic [REG_ADDR_W-1:0] cancel_rd,
  output logic                  err_underflow
);
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:1] uf;
  logic fire;
  // x0 is never written, so the array read already yields zero for it
  always_ff @(posedge clk)
    if (rst) for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    else if (wb_rf_wb && wb_rd != '0) regs[wb_rd] <= wb_data;
  assign cnt[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    pending_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(fire && issue_rd == REG_ADDR_W'(i)),
      .dec_a(wb_rf_wb && wb_rd == REG_ADDR_W'(i)),
      .dec_b(cancel_valid && cancel_rd == REG_ADDR_W'(i)),
      .cnt(cnt[i]),
      .underflow(uf[i])
    );
  end
`ifdef RF_BYPASS_EN
  logic wb_hit1, wb_hit2, cn_hit1, cn_hit2;
  assign wb_hit1 = wb_rf_wb && wb_rd == rs1_addr && rs1_addr != '0;
  assign wb_hit2 = wb_rf_wb && wb_rd == rs2_addr && rs2_addr != '0;
  assign cn_hit1 = cancel_valid && cancel_rd == rs1_addr;
  assign cn_hit2 = cancel_valid && cancel_rd == rs2_addr;
  assign rs1_data = wb_hit1 ? wb_data : regs[rs1_addr];
  assign rs2_data = wb_hit2 ? wb_data : regs[rs2_addr];
  assign rs1_busy = int'(cnt[rs1_addr]) > int'(wb_hit1) + int'(cn_hit1);
  assign rs2_busy = int'(cnt[rs2_addr]) > int'(wb_hit2) + int'(cn_hit2);
`else
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign rs1_busy = cnt[rs1_addr] != '0;
  assign rs2_busy = cnt[rs2_addr] != '0;
`endif
  assign issue_ready = cnt[issue_rd] != '1;
  assign hazard_stall = rs1_busy | rs2_busy | (issue_valid & issue_rf_wb & ~issue_ready);
  assign fire = issue_valid & issue_rf_wb & (issue_rd != '0) & ~hazard_stall;
  always_ff @(posedge clk)
    if (rst) err_underflow <= 1'b0;
    else err_underflow <= err_underflow | (|uf);
endmodule
